// File: rtl/param_bidir_mem_if.sv
// Request/status bundle for param_bidir_mem.
// The shared tristate data bus is a plain inout port of the memory, outside this bundle.
interface param_bidir_mem_if #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16
);
   localparam int AW = $clog2(DEPTH);

   logic            wr_en;
   logic            rd_en;
   logic [AW-1:0]   addr;
   logic [WIDTH/8-1:0] be;
   logic            rd_valid;
   logic            busy;
   logic            err;

   modport master (
      output wr_en, rd_en, addr, be,
      input  rd_valid, busy, err
   );

   modport slave (
      input  wr_en, rd_en, addr, be,
      output rd_valid, busy, err
   );
endinterface

// File: rtl/param_bidir_mem.sv
// Single-port WIDTH x DEPTH memory on a shared tristate data bus, with byte enables,
// a RD_LAT-deep read pipeline, an optional post-reset clear sweep and an error strobe.
module param_bidir_mem #(
   parameter int WIDTH      = 16,
   parameter int DEPTH      = 16,
   parameter int RD_LAT     = 1,
   parameter int INIT_CLEAR = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   inout  wire  [WIDTH-1:0] data,
   param_bidir_mem_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int NB = WIDTH / 8;

   typedef enum logic {
      INIT,
      IDLE
   } state_t;

   state_t            state;
   logic [AW-1:0]     clr_addr;
   logic              busy_q;
   logic              err_q;
   logic [WIDTH-1:0]  mem [DEPTH];
   logic [WIDTH-1:0]  pipe_data [RD_LAT];
   logic [RD_LAT-1:0] pipe_vld;
   logic              rd_valid;
   logic              wr_ok;
   logic              rd_ok;
   logic              bad_req;

   assign rd_valid = pipe_vld[RD_LAT-1];

   // A write is refused while read data owns the bus; a lone read never conflicts.
   always_comb begin
      wr_ok   = bus.wr_en && !bus.rd_en && !busy_q && !rd_valid;
      rd_ok   = bus.rd_en && !bus.wr_en && !busy_q;
      bad_req = (busy_q && (bus.wr_en || bus.rd_en))
              || (bus.wr_en && bus.rd_en)
              || (bus.wr_en && rd_valid);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= (INIT_CLEAR != 0) ? INIT : IDLE;
         busy_q   <= (INIT_CLEAR != 0);
         clr_addr <= '0;
         err_q    <= 1'b0;
         pipe_vld <= '0;
      end else begin
         err_q <= bad_req;
         case (state)
            INIT: begin
               if (clr_addr == AW'(DEPTH - 1)) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end else begin
                  clr_addr <= clr_addr + 1'b1;
               end
            end
            default: begin
               busy_q <= 1'b0;
            end
         endcase
         pipe_vld[0]  <= rd_ok;
         pipe_data[0] <= mem[bus.addr];
         for (int i = 1; i < RD_LAT; i++) begin
            pipe_vld[i]  <= pipe_vld[i-1];
            pipe_data[i] <= pipe_data[i-1];
         end
      end
   end

   // Storage is never touched by reset itself, only by the sweep or accepted writes.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (state == INIT) begin
            mem[clr_addr] <= '0;
         end else if (wr_ok) begin
            for (int i = 0; i < NB; i++) begin
               if (bus.be[i]) begin
                  mem[bus.addr][8*i +: 8] <= data[8*i +: 8];
               end
            end
         end
      end
   end

   assign data     = rd_valid ? pipe_data[RD_LAT-1] : 'z;
   assign bus.rd_valid = rd_valid;
   assign bus.busy     = busy_q;
   assign bus.err      = err_q;
endmodule

// File: tb/tb_param_bidir_mem.sv
// Scoreboard bench for param_bidir_mem: directed test-plan sequences followed by random traffic,
// checked against a cycle-stamped behavioural model.
module tb_param_bidir_mem;
   localparam int WIDTH  = 16;
   localparam int DEPTH  = 16;
   localparam int RD_LAT = 3;
   localparam int AW     = $clog2(DEPTH);
   localparam int MAXC   = 4096;

   typedef struct {
      int               cycle;
      logic [WIDTH-1:0] value;
   } rd_item_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             drv_en = 1'b0;
   logic [WIDTH-1:0] drv_data = '0;
   wire  [WIDTH-1:0] data;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int last_e = 0;

   rd_item_t         rd_q[$];
   rd_item_t         item;
   logic [WIDTH-1:0] model_mem [DEPTH];
   bit               valid_at [MAXC];
   bit               exp_err [MAXC];
   bit               exp_busy [MAXC];
   int               clear_idx = 0;
   bit               busy_m = 1'b1;

   param_bidir_mem_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   param_bidir_mem #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .RD_LAT(RD_LAT), .INIT_CLEAR(1)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .data(data),
      .bus(bus)
   );

   assign data = drv_en ? drv_data : 'z;
   pullup (data);

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, req);
      end
   endtask

   // Drives one edge worth of inputs and records what the model says must follow that edge.
   task automatic applyStimulus(input bit rst, input bit w, input bit r, input int a,
                                input logic [WIDTH/8-1:0] b, input logic [WIDTH-1:0] d);
      int               e;
      bit               off;
      logic [WIDTH-1:0] mask;
      e = cyc + 1;
      off = 1'b0;
      rst_n      = !rst;
      bus.wr_en  = w;
      bus.rd_en  = r;
      bus.addr   = AW'(a);
      bus.be     = b;
      drv_en     = w && !valid_at[e-1];
      drv_data   = d;
      if (rst) begin
         while (rd_q.size() > 0 && rd_q[$].cycle >= e) void'(rd_q.pop_back());
         for (int c = e; c <= e + RD_LAT; c++) valid_at[c] = 1'b0;
         clear_idx   = 0;
         busy_m      = 1'b1;
         exp_err[e]  = 1'b0;
         exp_busy[e] = 1'b1;
      end else begin
         if (busy_m) begin
            off = w || r;
            model_mem[clear_idx] = '0;
            clear_idx++;
            if (clear_idx == DEPTH) busy_m = 1'b0;
         end else if (w && r) begin
            off = 1'b1;
         end else if (w) begin
            if (valid_at[e-1]) begin
               off = 1'b1;
            end else begin
               mask = '0;
               for (int i = 0; i < WIDTH/8; i++) if (b[i]) mask |= WIDTH'(8'hFF) << (8*i);
               model_mem[a] = (model_mem[a] & ~mask) | (d & mask);
            end
         end else if (r) begin
            rd_q.push_back('{cycle: e + RD_LAT - 1, value: model_mem[a]});
            valid_at[e + RD_LAT - 1] = 1'b1;
         end
         exp_err[e]  = off;
         exp_busy[e] = busy_m;
      end
      last_e = e;
      @(posedge clk);
      #1;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, '0, '0);
   endtask

   task automatic writeWord(input int a, input logic [WIDTH/8-1:0] b, input logic [WIDTH-1:0] d);
      applyStimulus(0, 1, 0, a, b, d);
   endtask

   task automatic readWord(input int a);
      applyStimulus(0, 0, 1, a, '0, '0);
   endtask

   // Monitor: compares every DUT-visible output of each cycle against the model's record.
   always @(negedge clk) begin
      if (cyc >= 1 && cyc <= last_e) begin
         checkOutput("err", 32'(bus.err), 32'(exp_err[cyc]));
         checkOutput("busy", 32'(bus.busy), 32'(exp_busy[cyc]));
         checkOutput("rd_valid", 32'(bus.rd_valid), 32'(valid_at[cyc]));
         if (valid_at[cyc]) begin
            if (rd_q.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL scoreboard at cycle %0d: read expected but queue empty", cyc);
            end else begin
               item = rd_q.pop_front();
               checkOutput("rd_data", 32'(data), 32'(item.value));
            end
         end else if (!drv_en) begin
            checkOutput("bus_release", 32'(data), 32'({WIDTH{1'b1}}));
         end
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      bus.addr  = '0;
      bus.be    = '0;
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;

      applyStimulus(1, 0, 0, 0, '0, '0);
      applyStimulus(1, 0, 0, 0, '0, '0);
      idleCycles(5);
      writeWord(4, 2'b11, 16'hDEAD);
      readWord(4);
      idleCycles(DEPTH);
      for (int a = 0; a < DEPTH; a++) readWord(a);
      idleCycles(RD_LAT + 1);

      writeWord(3, 2'b11, 16'hA5C3);
      writeWord(3, 2'b01, 16'h00FF);
      readWord(3);
      idleCycles(RD_LAT + 1);

      writeWord(1, 2'b11, 16'h1111);
      writeWord(2, 2'b11, 16'h2222);
      writeWord(3, 2'b11, 16'h3333);
      readWord(1);
      readWord(2);
      readWord(3);
      idleCycles(RD_LAT + 1);

      writeWord(5, 2'b11, 16'h1234);
      readWord(5);
      writeWord(5, 2'b11, 16'hBEEF);
      idleCycles(RD_LAT);
      readWord(5);
      idleCycles(RD_LAT + 1);

      writeWord(7, 2'b11, 16'h7777);
      applyStimulus(0, 1, 1, 7, 2'b11, 16'h1111);
      applyStimulus(0, 1, 1, 7, 2'b11, 16'h2222);
      readWord(7);
      idleCycles(RD_LAT - 1);
      writeWord(7, 2'b11, 16'h9999);
      idleCycles(RD_LAT);
      readWord(7);
      idleCycles(RD_LAT + 1);

      readWord(2);
      applyStimulus(1, 0, 0, 0, '0, '0);
      idleCycles(DEPTH + 2);
      readWord(2);
      idleCycles(RD_LAT + 1);

      for (int n = 0; n < 500; n++) begin
         int rnd;
         rnd = int'($urandom_range(0, 199));
         if (rnd == 0)
            applyStimulus(1, 0, 0, 0, '0, '0);
         else if (rnd < 80)
            writeWord(int'($urandom_range(0, DEPTH-1)), 2'($urandom), 16'($urandom));
         else if (rnd < 160)
            readWord(int'($urandom_range(0, DEPTH-1)));
         else if (rnd < 170)
            applyStimulus(0, 1, 1, int'($urandom_range(0, DEPTH-1)), 2'($urandom), 16'($urandom));
         else
            idleCycles(1);
      end
      idleCycles(DEPTH + RD_LAT + 2);

      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
